// File: rtl/prince_nf_round_ctrl_pkg.sv
// prince_nf_pkg: shared states, linear-layer codes and layer decode for the PRINCE NullFresh controller (PRINCE_NF_CTRL_ZEROIZE_EN adds ZERO)
package prince_nf_pkg;
  localparam int NUM_LAYERS = 12;
  localparam int MID_FWD_LAYER = 5;
  localparam int MID_INV_LAYER = 6;
  localparam logic [1:0] LIN_M = 2'd0;
  localparam logic [1:0] LIN_MP = 2'd1;
  localparam logic [1:0] LIN_MINV = 2'd2;
  localparam logic [1:0] LIN_BYP = 2'd3;
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SBOX,
    FINAL
`ifdef PRINCE_NF_CTRL_ZEROIZE_EN
    , ZERO
`endif
  } state_t;
  function automatic logic [1:0] lin_of(input logic [3:0] layer);
    return layer < 4'(MID_FWD_LAYER) ? LIN_M :
           layer == 4'(MID_FWD_LAYER) ? LIN_MP :
           layer == 4'(MID_INV_LAYER) ? LIN_BYP : LIN_MINV;
  endfunction
  // the last layer shares RC 11 with the output whitening
  function automatic logic [3:0] rc_of(input logic [3:0] layer);
    return layer == 4'(NUM_LAYERS - 1) ? layer : layer + 4'd1;
  endfunction
endpackage

// File: rtl/prince_nf_round_ctrl_if.sv
// prince_nf_round_ctrl_if: start/busy/done handshake and datapath strobes of the round controller
interface prince_nf_round_ctrl_if #(parameter int S_STAGES = 4);
  logic start;
  logic busy;
  logic done;
  logic load_en;
  logic [S_STAGES-1:0] stage_en;
  logic state_en;
  logic [1:0] lin_sel;
  logic [3:0] rc_idx;
  logic clr_state;
  modport master (output start, input busy, done, load_en, stage_en, state_en, lin_sel, rc_idx, clr_state);
  modport slave (input start, output busy, done, load_en, stage_en, state_en, lin_sel, rc_idx, clr_state);
endinterface

// File: rtl/prince_nf_round_ctrl_stage_seq.sv
// prince_nf_stage_seq: per-layer S-box stage counter with one-hot enables and last-stage pulse
module prince_nf_stage_seq #(parameter int S_STAGES = 4) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic [S_STAGES-1:0] stage_en,
  output logic last_stage
);
  localparam int SW = S_STAGES > 1 ? $clog2(S_STAGES) : 1;
  logic [SW-1:0] stage;
  assign last_stage = en && stage == SW'(S_STAGES - 1);
  assign stage_en = en ? S_STAGES'(1) << stage : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) stage <= '0;
    else if (clr) stage <= '0;
    else if (en) stage <= last_stage ? '0 : stage + 1'b1;
endmodule

// File: rtl/prince_nf_round_ctrl.sv
// prince_nf_round_ctrl: PRINCE NullFresh round/stage sequencer; PRINCE_NF_CTRL_ZEROIZE_EN adds a share-clearing ZERO cycle
module prince_nf_round_ctrl #(parameter int S_STAGES = 4) (
  input logic clk,
  input logic rst,
  prince_nf_round_ctrl_if.slave bus
);
  import prince_nf_pkg::*;
`ifdef PRINCE_NF_CTRL_ZEROIZE_EN
  localparam state_t LAST = ZERO;
`else
  localparam state_t LAST = FINAL;
`endif
  state_t state, next;
  logic [3:0] layer;
  logic last_stage, in_sbox, done_q;
  logic [S_STAGES-1:0] stage_en;
  assign in_sbox = state == SBOX;
  prince_nf_stage_seq #(.S_STAGES(S_STAGES)) u_seq (
    .clk(clk),
    .rst(rst),
    .clr(state == LOAD),
    .en(in_sbox),
    .stage_en(stage_en),
    .last_stage(last_stage)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      layer <= '0;
      done_q <= 1'b0;
    end else begin
      state <= next;
      done_q <= state == LAST;
      layer <= state == LOAD ? '0 :
               (in_sbox && last_stage && layer != 4'(NUM_LAYERS - 1)) ? layer + 4'd1 : layer;
    end
  always_comb begin
    next = state;
    case (state)
      IDLE: next = bus.start ? LOAD : IDLE;
      LOAD: next = SBOX;
      SBOX: next = (last_stage && layer == 4'(NUM_LAYERS - 1)) ? FINAL : SBOX;
`ifdef PRINCE_NF_CTRL_ZEROIZE_EN
      FINAL: next = ZERO;
`endif
      default: next = IDLE;
    endcase
  end
  assign bus.busy = state != IDLE;
  assign bus.done = done_q;
  assign bus.load_en = state == LOAD;
  assign bus.stage_en = stage_en;
  assign bus.state_en = (in_sbox && last_stage) || state == FINAL;
  assign bus.lin_sel = in_sbox ? lin_of(layer) : state == FINAL ? LIN_BYP : LIN_M;
  assign bus.rc_idx = in_sbox ? rc_of(layer) : state == FINAL ? 4'(NUM_LAYERS - 1) : 4'd0;
`ifdef PRINCE_NF_CTRL_ZEROIZE_EN
  assign bus.clr_state = state == ZERO;
`else
  assign bus.clr_state = 1'b0;
`endif
endmodule

// File: tb/tb_prince_nf_round_ctrl.sv
// tb_prince_nf_round_ctrl: directed checks of the round controller timing against a per-cycle table
module tb_prince_nf_round_ctrl;
  localparam int S = 4;
`ifdef PRINCE_NF_CTRL_ZEROIZE_EN
  localparam int Z = 1;
`else
  localparam int Z = 0;
`endif
  localparam int T_FIN = 2 + 12 * S;
  localparam int T_DONE = T_FIN + 1 + Z;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [1:0] lin_tab [12] = '{0, 0, 0, 0, 0, 1, 3, 2, 2, 2, 2, 2};
  logic [3:0] rc_tab [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 11};
  prince_nf_round_ctrl_if #(.S_STAGES(S)) bus ();
  prince_nf_round_ctrl #(.S_STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // c = cycles since the start-accepting edge; 0 means idle
  task automatic expect_cycle(input string tag, input int c);
    logic [S+10:0] obs, exp;
    logic sbox;
    int k;
    sbox = c >= 2 && c < T_FIN;
    k = sbox ? c - 2 : 0;
    exp = {c >= 1 && c < T_DONE, c == T_DONE, c == 1,
           sbox ? S'(1) << (k % S) : S'(0),
           (sbox && k % S == S - 1) || c == T_FIN,
           sbox ? lin_tab[k / S] : c == T_FIN ? 2'd3 : 2'd0,
           sbox ? rc_tab[k / S] : c == T_FIN ? 4'd11 : 4'd0,
           Z == 1 && c == T_FIN + 1};
    obs = {bus.busy, bus.done, bus.load_en, bus.stage_en, bus.state_en, bus.lin_sel, bus.rc_idx, bus.clr_state};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: got %h expected %h", tag, c, obs, exp);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    expect_cycle("reset", 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      expect_cycle("idle", 0);
    end
    bus.start = 1'b1;
    for (int c = 1; c <= T_DONE; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      expect_cycle("single", c);
    end
    repeat (2) begin
      @(negedge clk);
      expect_cycle("post_single", 0);
    end
    bus.start = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int c = 1; c <= T_DONE; c++) begin
        @(negedge clk);
        expect_cycle(r == 0 ? "b2b_first" : "b2b_second", c);
      end
    bus.start = 1'b0;
    @(negedge clk);
    expect_cycle("b2b_end", 0);
    bus.start = 1'b1;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      expect_cycle("pre_reset", c);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_cycle("async_reset", 0);
    @(negedge clk);
    expect_cycle("reset_hold", 0);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      expect_cycle("no_done", 0);
    end
    bus.start = 1'b1;
    for (int c = 1; c <= T_DONE; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      expect_cycle("rerun", c);
    end
    @(negedge clk);
    expect_cycle("rerun_end", 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
